// File: rtl/morse_pkg.sv
// Shared types and the Morse-to-digit lookup for the Morse digit decoder.
package morse_pkg;

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    localparam logic [5:0] BLANK = 6'b111111;

    // sym holds the first symbol in bit 4; 1 = dash, 0 = dot.
    function automatic logic [5:0] morse_to_digit(input logic [4:0] sym);
        logic [5:0] digit;
        case (sym)
            5'b01111: digit = 6'd1;
            5'b00111: digit = 6'd2;
            5'b00011: digit = 6'd3;
            5'b00001: digit = 6'd4;
            5'b00000: digit = 6'd5;
            5'b10000: digit = 6'd6;
            5'b11000: digit = 6'd7;
            5'b11100: digit = 6'd8;
            5'b11110: digit = 6'd9;
            5'b11111: digit = 6'd0;
            default:  digit = BLANK;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/morse_symbol_timer.sv
// Press and gap counters for one Morse key: dot/dash classification and
// end-of-character detection. Both counters saturate instead of wrapping.
module morse_symbol_timer #(
    parameter int DOT_MAX    = 4,
    parameter int GAP_CYCLES = 10,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic press_load,
    input  logic press_inc,
    input  logic gap_load,
    input  logic gap_inc,
    output logic is_dash,
    output logic gap_done
);

    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] gap_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            if (press_load)
                press_cnt <= CNT_W'(1);
            else if (press_inc && press_cnt != '1)
                press_cnt <= press_cnt + CNT_W'(1);

            if (gap_load)
                gap_cnt <= CNT_W'(1);
            else if (gap_inc && gap_cnt != '1)
                gap_cnt <= gap_cnt + CNT_W'(1);
        end
    end

    assign is_dash  = press_cnt > CNT_W'(DOT_MAX);
    assign gap_done = gap_cnt == CNT_W'(GAP_CYCLES - 1);

endmodule

// File: rtl/morse_digit_decoder.sv
// Collects timed dots/dashes from one Morse key into a 5-symbol digit and
// presents a registered 0..9 / BLANK code to the 7-segment display stage.
module morse_digit_decoder
    import morse_pkg::*;
#(
    parameter int DOT_MAX    = 4,
    parameter int GAP_CYCLES = 10,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key,
    output logic [5:0] state,
    output logic       digit_valid,
    output logic       error,
    output logic       busy
);

    state_t     fsm;
    logic [4:0] sym;
    logic [2:0] sym_cnt;
    logic       is_dash;
    logic       gap_done;
    logic [5:0] code;

    morse_symbol_timer #(
        .DOT_MAX   (DOT_MAX),
        .GAP_CYCLES(GAP_CYCLES),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .press_load(key && fsm != PRESS),
        .press_inc (key && fsm == PRESS),
        .gap_load  (!key && fsm == PRESS),
        .gap_inc   (!key && fsm == GAP),
        .is_dash   (is_dash),
        .gap_done  (gap_done)
    );

    // Anything other than exactly five symbols, including overflow, is not a digit.
    assign code = (sym_cnt == 3'd5) ? morse_to_digit(sym) : BLANK;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm         <= IDLE;
            sym         <= '0;
            sym_cnt     <= '0;
            state       <= BLANK;
            digit_valid <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (key) begin
                        fsm  <= PRESS;
                        busy <= 1'b1;
                    end
                end
                PRESS: begin
                    if (!key) begin
                        sym <= {sym[3:0], is_dash};
                        if (sym_cnt != 3'd6)
                            sym_cnt <= sym_cnt + 3'd1;
                        fsm <= GAP;
                    end
                end
                GAP: begin
                    if (key) begin
                        fsm <= PRESS;
                    end else if (gap_done) begin
                        fsm         <= EMIT;
                        busy        <= 1'b0;
                        digit_valid <= 1'b1;
                        state       <= code;
                        error       <= (code == BLANK);
                        sym         <= '0;
                        sym_cnt     <= '0;
                    end
                end
                EMIT: begin
                    // A press starting here is counted from this very cycle.
                    if (key) begin
                        fsm  <= PRESS;
                        busy <= 1'b1;
                    end else begin
                        fsm <= IDLE;
                    end
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_digit_decoder.sv
// Directed bench for morse_digit_decoder: expected emits are queued as each
// character is keyed and compared whenever digit_valid pulses.
`timescale 1ns/1ps
module tb_morse_digit_decoder;
    import morse_pkg::*;

    typedef struct packed {
        logic [5:0] st;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key;
    logic [5:0] state;
    logic       digit_valid;
    logic       error;
    logic       busy;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    morse_digit_decoder #(
        .DOT_MAX   (4),
        .GAP_CYCLES(10),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key        (key),
        .state      (state),
        .digit_valid(digit_valid),
        .error      (error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int len);
        key = 1'b1;
        repeat (len) cycle();
        key = 1'b0;
    endtask

    task automatic idle_key(input int len);
        key = 1'b0;
        repeat (len) cycle();
    endtask

    // Keys n symbols with 3-cycle gaps; optionally ends the character with 10 released cycles.
    task automatic send(input int n, input int l0, input int l1, input int l2,
                        input int l3, input int l4, input int l5, input bit finish);
        int lens[6];
        lens = '{l0, l1, l2, l3, l4, l5};
        for (int i = 0; i < n; i++) begin
            press(lens[i]);
            if (i < n - 1) idle_key(3);
        end
        if (finish) idle_key(10);
    endtask

    task automatic push(input logic [5:0] st, input logic err);
        exp_t e;
        e.st  = st;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) cycle();
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (digit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_emit", {31'b0, digit_valid}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("emit_state", {26'b0, state}, {26'b0, mon_e.st});
                check("emit_error", {31'b0, error}, {31'b0, mon_e.err});
                check("emit_busy", {31'b0, busy}, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        key     = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        check("rst_state", {26'b0, state}, {26'b0, BLANK});
        check("rst_valid", {31'b0, digit_valid}, 0);
        check("rst_error", {31'b0, error}, 0);
        check("rst_busy", {31'b0, busy}, 0);

        // 1. idle: nothing may be emitted
        idle_key(20);
        check("idle_state", {26'b0, state}, {26'b0, BLANK});
        check("idle_error", {31'b0, error}, 0);
        check("idle_busy", {31'b0, busy}, 0);

        // 2. digit 3
        push(6'd3, 1'b0);
        key = 1'b1;
        cycle();
        check("press_busy", {31'b0, busy}, 1);
        press(1);
        idle_key(3);
        send(4, 2, 2, 8, 8, 0, 0, 1'b1);
        drain();
        check("d3_state_hold", {26'b0, state}, 32'd3);
        check("d3_busy_after", {31'b0, busy}, 0);

        // 3. digit 0, then 9 starting in the EMIT cycle of 0
        push(6'd0, 1'b0);
        push(6'd9, 1'b0);
        send(5, 6, 6, 6, 6, 6, 0, 1'b1);
        send(5, 6, 6, 6, 6, 3, 0, 1'b1);
        drain();
        check("d9_state_hold", {26'b0, state}, 32'd9);

        // 4. too few symbols, overflow, then a valid 5
        push(BLANK, 1'b1);
        send(4, 2, 2, 2, 2, 0, 0, 1'b1);
        drain();
        check("short_error", {31'b0, error}, 1);
        push(BLANK, 1'b1);
        send(6, 6, 6, 6, 6, 6, 6, 1'b1);
        drain();
        check("ovf_state", {26'b0, state}, {26'b0, BLANK});
        push(6'd5, 1'b0);
        send(5, 2, 2, 2, 2, 2, 0, 1'b1);
        drain();
        check("d5_error_cleared", {31'b0, error}, 0);

        // 5. press saturating the 16-bit counter is still a dash
        push(6'd0, 1'b0);
        key = 1'b1;
        repeat (70000) cycle();
        check("long_busy", {31'b0, busy}, 1);
        idle_key(3);
        send(4, 6, 6, 6, 6, 0, 0, 1'b1);
        drain();

        // 6. reset mid-character discards the partial symbols
        send(3, 2, 6, 6, 0, 0, 0, 1'b0);
        idle_key(3);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("midrst_state", {26'b0, state}, {26'b0, BLANK});
        check("midrst_busy", {31'b0, busy}, 0);
        push(6'd1, 1'b0);
        send(5, 2, 6, 6, 6, 6, 0, 1'b1);
        drain();
        check("d1_state_hold", {26'b0, state}, 32'd1);
        idle_key(15);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
